// File: rtl/vc_test_seq_pkg.sv
// vc_test_seq_pkg
// Shared types and constants for the test-case sequencer.
//   - DEF_CASE_W / DEF_CNT_W : default widths of case numbers and the failure count
//   - ST_*                   : state encoding constants
//   - seq_state_e            : sequencer state enum, IDLE..DONE
//   - maxOf3                 : helper used to size the shared interval counter
package vc_test_seq_pkg;

  localparam int DEF_CASE_W = 10;
  localparam int DEF_CNT_W  = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    LAUNCH = ST_LAUNCH,
    RUN    = ST_RUN,
    DRAIN  = ST_DRAIN,
    DONE   = ST_DONE
  } seq_state_e;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vc_test_case_sequencer_if.sv
// vc_test_case_sequencer_if
// Bundles the suite-control and case-handshake signals of the sequencer.
//   master : the bench side; drives start/case_only/last_case/case_done/case_fail
//            and observes case_num/case_start/fail_count/timeout/proto_err/
//            suite_done/finish
//   slave  : the sequencer itself (directions reversed)
// Parameters: CASE_W (case number width), CNT_W (failure counter width).
interface vc_test_case_sequencer_if
  import vc_test_seq_pkg::*;
#(
  parameter int CASE_W = DEF_CASE_W,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic              start;
  logic [CASE_W-1:0] case_only;
  logic [CASE_W-1:0] last_case;
  logic              case_done;
  logic              case_fail;

  logic [CASE_W-1:0] case_num;
  logic              case_start;
  logic [CNT_W-1:0]  fail_count;
  logic              timeout;
  logic              proto_err;
  logic              suite_done;
  logic              finish;

  modport master (
    output start, case_only, last_case, case_done, case_fail,
    input  case_num, case_start, fail_count, timeout, proto_err, suite_done, finish
  );

  modport slave (
    input  start, case_only, last_case, case_done, case_fail,
    output case_num, case_start, fail_count, timeout, proto_err, suite_done, finish
  );

endinterface

// File: rtl/vc_test_seq_counter.sv
// vc_test_seq_counter
// Loadable down-counter with a zero flag. Counts down by one per cycle until it
// reaches zero and then rests there; a load takes priority over counting.
//   clk       : clock
//   reset     : asynchronous, active-low reset (count returns to zero)
//   load      : load loadValue this cycle
//   loadValue : value to load
//   zero      : count is zero
module vc_test_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  output logic         zero
);

  logic [W-1:0] count;

  // The counter only ever moves towards zero, so the owner can load an
  // interval and simply watch the zero flag to know when it has elapsed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vc_test_case_sequencer.sv
// vc_test_case_sequencer
// Issues test-case numbers in order (or one selected case), hands each case to
// the bench body with a start pulse, waits for completion, counts failures,
// flags protocol misuse, drains and then signals the end of the suite.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : vc_test_case_sequencer_if.slave
//           in  start, case_only, last_case, case_done, case_fail
//           out case_num, case_start, fail_count, timeout, proto_err,
//               suite_done, finish (all registered)
// Build option: define VC_TEST_SEQ_TIMEOUT_EN to compile in the per-case
// watchdog; without it timeout is tied low and RUN waits for case_done forever.
module vc_test_case_sequencer
  import vc_test_seq_pkg::*;
#(
  parameter int CASE_W         = DEF_CASE_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int SETTLE_CYCLES  = 2,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                     clk,
  input logic                     reset,
  vc_test_case_sequencer_if.slave bus
);

  // DRAIN is entered on the edge after the last completion and finish must
  // appear DRAIN_CYCLES later, so the counter is loaded one short.
  localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int TMR_MAX    = maxOf3(SETTLE_CYCLES, DRAIN_LOAD, TIMEOUT_CYCLES);
  localparam int TMR_W      = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

`ifdef VC_TEST_SEQ_TIMEOUT_EN
  localparam logic WDOG_ON = 1'b1;
`else
  localparam logic WDOG_ON = 1'b0;
`endif

  seq_state_e        state, stateNext;
  logic [CASE_W-1:0] caseOnlyQ, lastCaseQ;
  logic              noCaseQ;
  logic [CASE_W-1:0] caseNumQ, caseNumNext;
  logic              caseStartQ, suiteDoneQ, finishQ;
  logic [CNT_W-1:0]  failCountQ;
  logic              protoErrQ, timeoutQ;

  logic              tmrLoad;
  logic [TMR_W-1:0]  tmrLoadValue;
  logic              tmrZero;

  logic              acceptStart, inCase, expiry, advance, lastOne, protoHit;
  logic [1:0]        failInc;
  logic [CNT_W:0]    failSum;

  // One counter times SETTLE, DRAIN and the watchdog; they never overlap.
  vc_test_seq_counter #(.W(TMR_W)) u_tmr (
    .clk       (clk),
    .reset     (reset),
    .load      (tmrLoad),
    .loadValue (tmrLoadValue),
    .zero      (tmrZero)
  );

  assign inCase  = (state == LAUNCH) || (state == RUN);
  assign advance = (inCase && bus.case_done) || expiry;
  // Single-case mode always ends after one case; otherwise stop at last_case.
  assign lastOne = (caseOnlyQ != '0) || (caseNumQ == lastCaseQ);

`ifdef VC_TEST_SEQ_TIMEOUT_EN
  // A real completion in the same cycle wins over the watchdog.
  assign expiry = (state == RUN) && tmrZero && !bus.case_done;

  // The timeout flag is sticky for the suite and cleared by the next start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeoutQ <= 1'b0;
    end else if (acceptStart) begin
      timeoutQ <= 1'b0;
    end else if (expiry) begin
      timeoutQ <= 1'b1;
    end
  end
`else
  assign expiry   = 1'b0;
  assign timeoutQ = 1'b0;
`endif

  // Next-state logic. Entering LAUNCH also picks the case number and rearms the
  // watchdog; entering SETTLE or DRAIN loads the corresponding interval.
  always_comb begin
    stateNext    = state;
    caseNumNext  = caseNumQ;
    tmrLoad      = 1'b0;
    tmrLoadValue = '0;
    acceptStart  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          acceptStart  = 1'b1;
          stateNext    = SETTLE;
          tmrLoad      = 1'b1;
          tmrLoadValue = TMR_W'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        if (tmrZero) begin
          if (noCaseQ) begin
            stateNext    = DRAIN;
            tmrLoad      = 1'b1;
            tmrLoadValue = TMR_W'(DRAIN_LOAD);
          end else begin
            stateNext    = LAUNCH;
            caseNumNext  = (caseOnlyQ != '0) ? caseOnlyQ : CASE_W'(1);
            tmrLoad      = WDOG_ON;
            tmrLoadValue = TMR_W'(TIMEOUT_CYCLES);
          end
        end
      end
      LAUNCH, RUN: begin
        stateNext = RUN;
        if (advance) begin
          if (lastOne) begin
            stateNext    = DRAIN;
            caseNumNext  = '0;
            tmrLoad      = 1'b1;
            tmrLoadValue = TMR_W'(DRAIN_LOAD);
          end else begin
            stateNext    = LAUNCH;
            caseNumNext  = caseNumQ + CASE_W'(1);
            tmrLoad      = WDOG_ON;
            tmrLoadValue = TMR_W'(TIMEOUT_CYCLES);
          end
        end
      end
      DRAIN: begin
        if (tmrZero) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Suite configuration is captured once when start is accepted. A suite with
  // no valid case still walks SETTLE and DRAIN so that finish always arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      caseOnlyQ <= '0;
      lastCaseQ <= '0;
      noCaseQ   <= 1'b0;
    end else if (acceptStart) begin
      caseOnlyQ <= bus.case_only;
      lastCaseQ <= bus.last_case;
      noCaseQ   <= (bus.last_case == '0) || (bus.case_only > bus.last_case);
    end
  end

  // Registered case outputs: case_start marks the first cycle of LAUNCH and
  // finish marks only the entry into DONE, while suite_done holds there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      caseNumQ   <= '0;
      caseStartQ <= 1'b0;
      suiteDoneQ <= 1'b0;
      finishQ    <= 1'b0;
    end else begin
      caseNumQ   <= caseNumNext;
      caseStartQ <= (stateNext == LAUNCH);
      suiteDoneQ <= (stateNext == DONE);
      finishQ    <= (stateNext == DONE) && (state != DONE);
    end
  end

  // A failed check and a watchdog expiry in the same cycle both count, so the
  // increment can be 2; the sum carries one extra bit to detect saturation.
  assign failInc  = 2'(inCase && bus.case_fail) + 2'(expiry);
  assign failSum  = {1'b0, failCountQ} + (CNT_W + 1)'(failInc);
  assign protoHit = !inCase && (bus.case_done || bus.case_fail);

  // Failure count and protocol-error flag live for one suite; accepting a new
  // start clears them, except that an out-of-range case_only flags at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      failCountQ <= '0;
      protoErrQ  <= 1'b0;
    end else if (acceptStart) begin
      failCountQ <= '0;
      protoErrQ  <= (bus.case_only > bus.last_case);
    end else begin
      failCountQ <= failSum[CNT_W] ? '1 : failSum[CNT_W-1:0];
      if (protoHit) begin
        protoErrQ <= 1'b1;
      end
    end
  end

  assign bus.case_num   = caseNumQ;
  assign bus.case_start = caseStartQ;
  assign bus.fail_count = failCountQ;
  assign bus.timeout    = timeoutQ;
  assign bus.proto_err  = protoErrQ;
  assign bus.suite_done = suiteDoneQ;
  assign bus.finish     = finishQ;

endmodule

// File: tb/tb_vc_test_case_sequencer.sv
// tb_vc_test_case_sequencer
// Self-checking bench for vc_test_case_sequencer. Each suite run is predicted by
// a reference model that lists the cases to launch and accumulates their
// durations into launch and finish times; the bench then acts as the case body,
// answering every case_start with done/fail pulses from a per-case table.
// The failure counter is built narrow so saturation is reachable.
module tb_vc_test_case_sequencer;

  localparam int CASE_W = 10;
  localparam int CNT_W  = 4;
  localparam int S      = 2;
  localparam int D      = 4;
  localparam int T      = 8;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  vc_test_case_sequencer_if #(.CASE_W(CASE_W), .CNT_W(CNT_W)) bus ();

  vc_test_case_sequencer #(
    .CASE_W(CASE_W), .CNT_W(CNT_W), .SETTLE_CYCLES(S),
    .DRAIN_CYCLES(D), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  // Per-case behaviour table: duration from case_start to case_done, number of
  // failure pulses, and (watchdog builds) whether the case hangs and whether a
  // failure lands on the expiry cycle.
  int durA[16];
  int nfailA[16];
  bit hangA[16];
  bit hangFailA[16];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clearCases();
    for (int i = 0; i < 16; i++) begin
      durA[i]      = 1;
      nfailA[i]    = 0;
      hangA[i]     = 1'b0;
      hangFailA[i] = 1'b0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/case_num"},   32'(bus.case_num),   0);
    checkOutput({tag, "/case_start"}, 32'(bus.case_start), 0);
    checkOutput({tag, "/fail_count"}, 32'(bus.fail_count), 0);
    checkOutput({tag, "/timeout"},    32'(bus.timeout),    0);
    checkOutput({tag, "/proto_err"},  32'(bus.proto_err),  0);
    checkOutput({tag, "/suite_done"}, 32'(bus.suite_done), 0);
    checkOutput({tag, "/finish"},     32'(bus.finish),     0);
  endtask

  // Runs one whole suite and compares it against the model's prediction.
  task automatic applyStimulus(input int lastCase, input int caseOnly,
                               input bit drainFail, input string name);
    int expCase[$];
    int expCyc[$];
    int obsCase[$];
    int obsCyc[$];
    int t, nextL, bigF, expFail, curCase, curL, finishCnt, finishCyc, c;
    bit expTimeout, expProto, active;

    if (lastCase != 0 && caseOnly <= lastCase) begin
      if (caseOnly != 0) expCase.push_back(caseOnly);
      else for (int k = 1; k <= lastCase; k++) expCase.push_back(k);
    end

    bus.start     = 1'b1;
    bus.case_only = CASE_W'(caseOnly);
    bus.last_case = CASE_W'(lastCase);
    step();
    t = cyc;
    bus.start     = 1'b0;
    bus.case_only = CASE_W'($urandom);
    bus.last_case = CASE_W'($urandom);

    nextL      = t + S + 1;
    expFail    = 0;
    expTimeout = 1'b0;
    foreach (expCase[i]) begin
      c = expCase[i];
      expCyc.push_back(nextL);
      expFail += nfailA[c];
      if (hangA[c]) begin
        nextL     += T + 1;
        expFail   += 1 + int'(hangFailA[c]);
        expTimeout = 1'b1;
      end else begin
        nextL += durA[c] + 1;
      end
    end
    bigF     = nextL + D;
    expFail  = (expFail > SAT) ? SAT : expFail;
    expProto = (caseOnly > lastCase) || drainFail;

    active    = 1'b0;
    curCase   = 0;
    curL      = 0;
    finishCnt = 0;
    finishCyc = -1;
    while (cyc < bigF + 3) begin
      if (bus.case_start === 1'b1) begin
        obsCyc.push_back(cyc - t);
        obsCase.push_back(int'(bus.case_num));
        curCase = int'(bus.case_num);
        curL    = cyc;
        active  = (curCase > 0) && (curCase < 16);
        if (!active) curCase = 0;
      end
      if (bus.finish === 1'b1) begin
        finishCnt++;
        finishCyc = cyc;
      end
      bus.case_done = active && !hangA[curCase] && (cyc == curL + durA[curCase]);
      bus.case_fail = (active && (cyc < curL + nfailA[curCase]))
                   || (active && hangA[curCase] && hangFailA[curCase] && (cyc == curL + T))
                   || (drainFail && (cyc == bigF - D + 1));
      step();
    end
    bus.case_done = 1'b0;
    bus.case_fail = 1'b0;

    checkOutput({name, "/launches"}, obsCase.size(), expCase.size());
    for (int i = 0; i < expCase.size() && i < obsCase.size(); i++) begin
      checkOutput({name, "/launch_case"},  obsCase[i], expCase[i]);
      checkOutput({name, "/launch_cycle"}, obsCyc[i],  expCyc[i] - t);
    end
    checkOutput({name, "/finish_pulses"}, finishCnt, 1);
    checkOutput({name, "/finish_cycle"},  finishCyc - t, bigF - t);
    checkOutput({name, "/suite_done"},    32'(bus.suite_done), 1);
    checkOutput({name, "/case_num_idle"}, 32'(bus.case_num), 0);
    checkOutput({name, "/fail_count"},    32'(bus.fail_count), expFail);
    checkOutput({name, "/proto_err"},     32'(bus.proto_err), 32'(expProto));
    checkOutput({name, "/timeout"},       32'(bus.timeout), 32'(expTimeout));
  endtask

  // Starts a suite, lets case 1 complete with one failure, then pulls reset
  // while case 2 is running and checks everything drops at once.
  task automatic resetMidRun();
    int curL;
    bit seen;
    clearCases();
    durA[1]   = 2;
    nfailA[1] = 1;
    durA[2]   = 30;
    bus.start     = 1'b1;
    bus.case_only = '0;
    bus.last_case = CASE_W'(3);
    step();
    bus.start = 1'b0;
    seen = 1'b0;
    curL = -100;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (bus.case_start === 1'b1 && bus.case_num == CASE_W'(1)) curL = cyc;
      if (bus.case_start === 1'b1 && bus.case_num == CASE_W'(2)) seen = 1'b1;
      bus.case_done = (cyc == curL + 2);
      bus.case_fail = (cyc == curL);
      if (!seen) step();
    end
    bus.case_done = 1'b0;
    bus.case_fail = 1'b0;
    checkOutput("rst/reached_case2", 32'(seen), 1);
    step();
    checkOutput("rst/pre_case_num",   32'(bus.case_num), 2);
    checkOutput("rst/pre_fail_count", 32'(bus.fail_count), 1);
    #2 reset = 1'b0;
    #1;
    checkAllZero("rst/async");
    step();
    checkOutput("rst/no_finish", 32'(bus.finish), 0);
    #2 reset = 1'b1;
  endtask

  initial begin
    int lastCase, caseOnly, r;
    bit drainFail;

    bus.start     = 1'b0;
    bus.case_only = '0;
    bus.last_case = '0;
    bus.case_done = 1'b0;
    bus.case_fail = 1'b0;
    clearCases();

    #2 reset = 1'b0;
    #1;
    checkAllZero("reset");
    step();
    step();
    #2 reset = 1'b1;
    step();
    checkAllZero("after_reset");

    // Handshake pulses while idle are misuse and are not counted.
    bus.case_done = 1'b1;
    bus.case_fail = 1'b1;
    step();
    bus.case_done = 1'b0;
    bus.case_fail = 1'b0;
    step();
    checkOutput("idle_misuse/proto_err",  32'(bus.proto_err), 1);
    checkOutput("idle_misuse/fail_count", 32'(bus.fail_count), 0);

    clearCases();
    for (int i = 1; i <= 3; i++) durA[i] = 2;
    applyStimulus(3, 0, 1'b0, "all3");

    for (int i = 1; i <= 5; i++) durA[i] = 2;
    applyStimulus(5, 2, 1'b0, "only2");
    applyStimulus(5, 7, 1'b0, "only7");
    applyStimulus(0, 0, 1'b0, "last0");

    clearCases();
    durA[1] = 3; nfailA[1] = 3;
    durA[2] = 1; nfailA[2] = 1;
    applyStimulus(2, 0, 1'b1, "fails");

    clearCases();
    for (int i = 1; i <= 4; i++) durA[i] = 0;
    applyStimulus(4, 0, 1'b0, "zero_len");

    clearCases();
    for (int i = 1; i <= 6; i++) begin
      durA[i]   = 3;
      nfailA[i] = 3;
    end
    applyStimulus(6, 0, 1'b0, "saturate");

`ifdef VC_TEST_SEQ_TIMEOUT_EN
    clearCases();
    hangA[1] = 1'b1;
    durA[2]  = 1;
    applyStimulus(2, 0, 1'b0, "watchdog");

    clearCases();
    hangA[3]     = 1'b1;
    hangFailA[3] = 1'b1;
    applyStimulus(5, 3, 1'b0, "watchdog_fail");
`endif

    resetMidRun();
    clearCases();
    applyStimulus(2, 0, 1'b0, "post_reset");

    for (int n = 0; n < 25; n++) begin
      clearCases();
      lastCase = int'($urandom_range(0, 6));
      r        = int'($urandom_range(0, 9));
      if (r < 5)      caseOnly = 0;
      else if (r < 8) caseOnly = int'($urandom_range(1, (lastCase > 0) ? lastCase : 1));
      else            caseOnly = lastCase + int'($urandom_range(1, 3));
      for (int c = 1; c <= 6; c++) begin
        durA[c]   = int'($urandom_range(0, 4));
        nfailA[c] = int'($urandom_range(0, (durA[c] + 1 < 3) ? durA[c] + 1 : 3));
`ifdef VC_TEST_SEQ_TIMEOUT_EN
        hangA[c]     = ($urandom_range(0, 5) == 0);
        hangFailA[c] = 1'($urandom_range(0, 1));
`endif
      end
      drainFail = 1'($urandom_range(0, 1));
      applyStimulus(lastCase, caseOnly, drainFail, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
